timer_sequencer: RTL and testbench

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_pkg.sv | 29 ++
 rtl/start_sync_edge.sv | 53 +++++
 rtl/timer_sequencer.sv | 160 ++++++++++++++++
 tb/tb_timer_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer: FSM state encoding,
// default timing parameters and a width helper for the internal counters.
package timer_pkg;

    localparam int TICK_DIV_DEFAULT    = 32'sd100000;
    localparam int BLINK_TICKS_DEFAULT = 32'sd500;

    // Externally visible state codes; only these four are ever produced.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_PAUSE = 3'b010,
        ST_DONE  = 3'b100
    } state_t;

    // Number of bits needed to hold the values 0 .. n_states-1 (never less than 1).
    function automatic int cnt_width(input int n_states);
        int w;
        int span;
        w    = 32'sd1;
        span = 32'sd2;
        while ((span < n_states) && (w < 32'sd31)) begin
            w    = w + 32'sd1;
            span = span * 32'sd2;
        end
        return w;
    endfunction

endpackage

// File: rtl/start_sync_edge.sv
// Start button conditioning: two-flop synchroniser followed by a rising-edge
// detector. The detector stays disarmed after reset until the synchronised
// input has genuinely been seen low, so a button held through reset release
// does not count as a press.
module start_sync_edge
    import timer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic fill1_r;
    logic fill2_r;
    logic armed_r;

    // Synchroniser chain plus one flop of history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    // Arm the detector once sync_r carries a real sample and that sample is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill1_r <= 1'b0;
            fill2_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            fill1_r <= 1'b1;
            fill2_r <= fill1_r;
            if (fill2_r && !sync_r) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign pulse = sync_r & ~prev_r & armed_r;

endmodule

// File: rtl/timer_sequencer.sv
// Control sequencer for a BCD stopwatch/timer: button handling, run/pause/done
// FSM, count-tick prescaler and done-state blink generator. All outputs are
// taken straight from flops.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int BLINK_TICKS = BLINK_TICKS_DEFAULT
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       m,
    input  logic       tc,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       cnt_load,
    output logic       cnt_dir,
    output logic [2:0] state,
    output logic       done_blink
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam int TW = cnt_width(BLINK_TICKS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 32'sd1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(BLINK_TICKS - 32'sd1);

    logic          press_s;
    logic          presc_at_last_s;
    logic [PW-1:0] presc_inc_s;
    logic          inc_hits_last_s;

    state_t        state_r;
    logic [PW-1:0] presc_r;
    logic [TW-1:0] tick_r;
    logic          blink_r;
    logic          en_r;
    logic          clr_r;
    logic          load_r;
    logic          dir_r;

    start_sync_edge u_start (
        .clk   (clk),
        .reset (reset),
        .din   (start),
        .pulse (press_s)
    );

    // Wrapping prescaler increment and the terminal-value decodes used by the FSM.
    always_comb begin
        presc_at_last_s = 1'b0;
        presc_inc_s     = '0;
        inc_hits_last_s = 1'b0;
        if (presc_r == PRESC_LAST) begin
            presc_at_last_s = 1'b1;
            presc_inc_s     = '0;
        end else begin
            presc_at_last_s = 1'b0;
            presc_inc_s     = presc_r + PW'(1'b1);
        end
        inc_hits_last_s = (presc_inc_s == PRESC_LAST);
    end

    // Main FSM with prescaler, blink counter and registered control pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            presc_r <= '0;
            tick_r  <= '0;
            blink_r <= 1'b0;
            en_r    <= 1'b0;
            clr_r   <= 1'b0;
            load_r  <= 1'b0;
            dir_r   <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            en_r   <= 1'b0;
            clr_r  <= 1'b0;
            load_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    presc_r <= '0;
                    tick_r  <= '0;
                    blink_r <= 1'b0;
                    if (press_s) begin
                        // Stopwatch starts from zero, timer starts from the preset.
                        state_r <= ST_RUN;
                        dir_r   <= m;
                        clr_r   <= ~m;
                        load_r  <= m;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tc) begin
                        // Terminal count wins over a simultaneous press.
                        state_r <= ST_DONE;
                        presc_r <= '0;
                        tick_r  <= '0;
                        blink_r <= 1'b1;
                    end else if (press_s) begin
                        // Freeze the prescaler so the partial tick survives the pause.
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_RUN;
                        presc_r <= presc_inc_s;
                        en_r    <= inc_hits_last_s;
                    end
                end
                ST_PAUSE: begin
                    if (press_s) begin
                        // Resume exactly where counting stopped; no clear or load.
                        state_r <= ST_RUN;
                        presc_r <= presc_inc_s;
                        en_r    <= inc_hits_last_s;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (press_s) begin
                        // Back to idle; the datapath keeps its value for display.
                        state_r <= ST_IDLE;
                        presc_r <= '0;
                        tick_r  <= '0;
                        blink_r <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                        presc_r <= presc_inc_s;
                        if (presc_at_last_s) begin
                            if (tick_r == TICK_LAST) begin
                                tick_r  <= '0;
                                blink_r <= ~blink_r;
                            end else begin
                                tick_r  <= tick_r + TW'(1'b1);
                            end
                        end else begin
                            tick_r <= tick_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    presc_r <= '0;
                    tick_r  <= '0;
                    blink_r <= 1'b0;
                end
            endcase
        end
    end

    assign state      = state_r;
    assign cnt_en     = en_r;
    assign cnt_clr    = clr_r;
    assign cnt_load   = load_r;
    assign cnt_dir    = dir_r;
    assign done_blink = blink_r;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer (TICK_DIV=4, BLINK_TICKS=2).
// The reference model tracks the sampled start history and counts of RUN and
// DONE cycles; expected outputs are derived from those counts arithmetically.
module tb_timer_sequencer;

    localparam int TD = 4;
    localparam int BT = 2;
    localparam logic [2:0] C_IDLE  = 3'b000;
    localparam logic [2:0] C_RUN   = 3'b001;
    localparam logic [2:0] C_PAUSE = 3'b010;
    localparam logic [2:0] C_DONE  = 3'b100;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       m;
    logic       tc;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cnt_load;
    logic       cnt_dir;
    logic [2:0] state;
    logic       done_blink;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    int md;
    int run_idx;
    int done_idx;
    bit fresh;
    bit mdir;
    bit samp[$];

    timer_sequencer #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .m          (m),
        .tc         (tc),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .cnt_load   (cnt_load),
        .cnt_dir    (cnt_dir),
        .state      (state),
        .done_blink (done_blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        md       = M_IDLE;
        run_idx  = 0;
        done_idx = 0;
        fresh    = 1'b0;
        mdir     = 1'b0;
        samp.delete();
    endfunction

    function automatic logic exp_en();
        return (md == M_RUN) && ((run_idx % TD) == (TD - 1));
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [2:0] sc;
        logic       clr;
        logic       ld;
        logic       bl;
        case (md)
            M_RUN:   sc = C_RUN;
            M_PAUSE: sc = C_PAUSE;
            M_DONE:  sc = C_DONE;
            default: sc = C_IDLE;
        endcase
        clr = (md == M_RUN) && fresh && !mdir;
        ld  = (md == M_RUN) && fresh && mdir;
        bl  = (md == M_DONE) && (((done_idx / (TD * BT)) % 2) == 0);
        return {sc, exp_en(), clr, ld, mdir, bl};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {state, cnt_en, cnt_clr, cnt_load, cnt_dir, done_blink};
    endfunction

    // One clock: sample inputs at the rising edge, update the model, return at the falling edge.
    task automatic advance();
        bit p;
        bit f;
        int k;
        @(posedge clk);
        samp.push_back(start);
        k = samp.size();
        // A press lands two edges after the first high sample that follows a real low sample.
        p = (k >= 4) && samp[k-3] && !samp[k-4];
        f = 1'b0;
        case (md)
            M_IDLE: if (p) begin md = M_RUN; run_idx = 0; f = 1'b1; mdir = m; end
            M_RUN: begin
                if (tc) begin md = M_DONE; done_idx = 0; end
                else if (p) md = M_PAUSE;
                else run_idx++;
            end
            M_PAUSE: if (p) begin md = M_RUN; run_idx++; end
            M_DONE: if (p) md = M_IDLE; else done_idx++;
            default: md = M_IDLE;
        endcase
        fresh = f;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tc    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) advance();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== 8'h00) $display("FAIL reset_state: got %b want %b", obs_vec(), 8'h00);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset_idle cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_stopwatch();
        int ens;
        int clrs;
        do_reset();
        m = 1'b0;
        ens = 0;
        clrs = 0;
        for (int i = 0; i < 16; i++) begin
            start = (i == 0) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL stopwatch cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (state !== C_IDLE) $display("FAIL stopwatch_not_early: got %b want %b", state, C_IDLE);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (state !== C_RUN) $display("FAIL stopwatch_third_edge: got %b want %b", state, C_RUN);
                else n_pass++;
            end
            if (cnt_en) ens++;
            if (cnt_clr) clrs++;
        end
        n_checks++;
        if ((ens !== 3) || (clrs !== 1)) $display("FAIL stopwatch_pulses: got en=%0d clr=%0d want en=3 clr=1", ens, clrs);
        else n_pass++;
    endtask

    task automatic test_pause_resume();
        int pause_cyc;
        int pause_en;
        pause_cyc = 0;
        pause_en  = 0;
        for (int i = 0; i < 20; i++) begin
            start = ((i == 0) || (i == 10)) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL pause_resume cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            if (state === C_PAUSE) begin
                pause_cyc++;
                if (cnt_en) pause_en++;
            end
        end
        n_checks++;
        if ((pause_cyc !== 10) || (pause_en !== 0)) $display("FAIL pause_window: got cycles=%0d en=%0d want cycles=10 en=0", pause_cyc, pause_en);
        else n_pass++;
    endtask

    task automatic test_timer_done();
        int toggles;
        int loads;
        logic prev_bl;
        logic prev_done;
        do_reset();
        toggles   = 0;
        loads     = 0;
        prev_bl   = 1'b0;
        prev_done = 1'b0;
        for (int i = 0; i < 38; i++) begin
            start = ((i == 0) || (i == 32)) ? 1'b1 : 1'b0;
            m     = (i < 4) ? 1'b1 : 1'b0;
            tc    = (i == 7) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL timer_done cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            if (cnt_load) loads++;
            if (prev_done && (state === C_DONE) && (done_blink !== prev_bl)) toggles++;
            prev_done = (state === C_DONE);
            prev_bl   = done_blink;
        end
        tc = 1'b0;
        n_checks++;
        if ((toggles !== 3) || (loads !== 1) || (cnt_dir !== 1'b1) || (state !== C_IDLE))
            $display("FAIL timer_summary: got toggles=%0d loads=%0d dir=%b state=%b want 3 1 1 000", toggles, loads, cnt_dir, state);
        else n_pass++;
    endtask

    task automatic test_held_start();
        int changes;
        logic [2:0] prev_st;
        do_reset();
        m = 1'b0;
        changes = 0;
        prev_st = C_IDLE;
        for (int i = 0; i < 25; i++) begin
            start = (i < 20) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL held_start cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            if (state !== prev_st) changes++;
            prev_st = state;
        end
        n_checks++;
        if ((changes !== 1) || (state !== C_RUN)) $display("FAIL held_single_press: got changes=%0d state=%b want 1 001", changes, state);
        else n_pass++;
    endtask

    task automatic test_press_tc_same();
        for (int i = 0; i < 6; i++) begin
            start = (i == 0) ? 1'b1 : 1'b0;
            tc    = (i == 2) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL press_tc cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (state !== C_DONE) $display("FAIL press_tc_priority: got %b want %b", state, C_DONE);
                else n_pass++;
            end
        end
        tc = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        do_reset();
        m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL midrun_pre cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        #6;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 8'h00) $display("FAIL reset_async: got %b want %b", obs_vec(), 8'h00);
        else n_pass++;
        #19;
        reset = 1'b0;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL midrun_post cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            if (cnt_en || cnt_clr || cnt_load) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL reset_residual: got %0d pulses want 0", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_held_start();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        tc    = 1'b0;
        m     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            start = ((i < 6) || (i >= 9)) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL held_reset cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 8) begin
                n_checks++;
                if (state !== C_IDLE) $display("FAIL held_reset_no_press: got %b want %b", state, C_IDLE);
                else n_pass++;
            end
        end
        n_checks++;
        if (state !== C_RUN) $display("FAIL held_reset_repress: got %b want %b", state, C_RUN);
        else n_pass++;
        start = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 250) begin
                reset = 1'b1;
                model_reset();
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) start = ~start;
            m  = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            tc = ((md == M_RUN) && !exp_en() && ($urandom_range(0, 29) == 0)) ? 1'b1 : 1'b0;
            advance();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            else n_pass++;
            n_checks++;
            if ((cnt_en + cnt_clr + cnt_load) > 1) $display("FAIL exclusive cyc%0d: got en=%b clr=%b load=%b", i, cnt_en, cnt_clr, cnt_load);
            else n_pass++;
        end
        tc = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        m     = 1'b0;
        tc    = 1'b0;
        model_reset();
        test_reset();
        test_stopwatch();
        test_pause_resume();
        test_timer_done();
        test_held_start();
        test_press_tc_same();
        test_reset_mid_run();
        test_reset_held_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
